// File: rtl/wb_stream_writer_fifo_pkg.sv
// Shared constants for the stream-writer FIFO: byte-lane shift and depth.
package wb_stream_writer_fifo_pkg;

  // log2 of bytes per data word; converts a byte length into a word count.
  function automatic int byte_shift(input int dw);
    return $clog2(dw / 8);
  endfunction

  // Number of words held by a FIFO with aw-bit pointers.
  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/wb_stream_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module wb_stream_fifo_ram #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read; output holds its value while re_i is low.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_stream_writer_fifo.sv
// Stream-writer FIFO: buffers Wishbone read data and presents it as a
// valid/ready stream with a last flag at every buffer boundary.
// The RAM read register doubles as the output register: valid_q says it
// holds the head word, so the head is always loaded one cycle after it is
// written (no bypass) and stays put while the sink stalls.
import wb_stream_writer_fifo_pkg::*;

module wb_stream_writer_fifo #(
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int FIFO_AW = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [WB_DW-1:0]   fifo_d,
  input  logic               fifo_wr,
  output logic [FIFO_AW:0]   fifo_cnt,
  input  logic               clr,
  input  logic [WB_AW-1:0]   buf_size,
  output logic [WB_DW-1:0]   stream_m_data_o,
  output logic               stream_m_valid_o,
  input  logic               stream_m_ready_i,
  output logic               stream_m_last_o,
  output logic               overflow_o
);

  localparam int DEPTH  = fifo_depth(FIFO_AW);
  localparam int BSHIFT = byte_shift(WB_DW);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

  if (FIFO_AW <= 0) begin : g_bad_aw
    $error("FIFO_AW must be greater than 0");
  end
  if (WB_DW % 8 != 0) begin : g_bad_dw
    $error("WB_DW must be a multiple of 8");
  end

  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d, ovf_q, ovf_d;
  logic [WB_AW-1:0]   word_cnt_q, word_cnt_d;
  logic [WB_AW-1:0]   bw_raw, buf_words;
  logic               full, wr_acc, xfer, mem_empty, load, last;

  // Handshake decode and buffer-length derived last flag.
  always_comb begin
    full      = (cnt_q == FULL_CNT);
    wr_acc    = fifo_wr && !full && !clr;
    xfer      = valid_q && stream_m_ready_i;
    // Words still in RAM = count minus the one sitting in the output register.
    mem_empty = (cnt_q == {{FIFO_AW{1'b0}}, valid_q});
    load      = !mem_empty && (!valid_q || stream_m_ready_i) && !clr;
    bw_raw    = buf_size >> BSHIFT;
    buf_words = (bw_raw == '0) ? WB_AW'(1) : bw_raw;
    // >= so a shrunken buffer size still forces a wrap on the next transfer.
    last      = valid_q && (word_cnt_q >= buf_words - WB_AW'(1));
  end

  // Next-state for pointers, count, output valid, word counter and overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    word_cnt_d = word_cnt_q;
    ovf_d      = ovf_q;
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      valid_d    = 1'b0;
      word_cnt_d = '0;
      ovf_d      = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      if (fifo_wr && full) ovf_d = 1'b1;
      if (load) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      case ({wr_acc, xfer})
        2'b10:   cnt_d = cnt_q + (FIFO_AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (FIFO_AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
      if (load)      valid_d = 1'b1;
      else if (xfer) valid_d = 1'b0;
      if (xfer) word_cnt_d = last ? '0 : word_cnt_q + WB_AW'(1);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      word_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      word_cnt_q <= word_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  wb_stream_fifo_ram #(
    .AW (FIFO_AW),
    .DW (WB_DW)
  ) u_ram (
    .clk_i   (wb_clk_i),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (fifo_d),
    .re_i    (load),
    .raddr_i (rd_ptr_q),
    .rdata_o (stream_m_data_o)
  );

  assign fifo_cnt         = cnt_q;
  assign stream_m_valid_o = valid_q;
  assign stream_m_last_o  = last;
  assign overflow_o       = ovf_q;

endmodule

// File: tb/tb_wb_stream_writer_fifo.sv
// Bench for wb_stream_writer_fifo: directed table, corner sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_wb_stream_writer_fifo;

  localparam int WB_AW = 32, WB_DW = 32, FIFO_AW = 4, DEPTH = 16;

  logic clk = 1'b0, rst = 1'b1, wr = 1'b0, clr = 1'b0, ready = 1'b0;
  logic [31:0] d = '0, bsz = 32'd64;
  logic [FIFO_AW:0] cnt;
  logic [31:0] dout;
  logic vld, lst, ovf;

  int n_cmp = 0, n_err = 0;

  // Reference model: queue of accepted words; head is presented once it
  // has been in the FIFO across at least one edge.
  int unsigned mq[$];
  bit m_pres = 1'b0, m_ovf = 1'b0;
  int m_wc = 0;

  wb_stream_writer_fifo #(.WB_AW(WB_AW), .WB_DW(WB_DW), .FIFO_AW(FIFO_AW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .fifo_d(d), .fifo_wr(wr), .fifo_cnt(cnt),
    .clr(clr), .buf_size(bsz), .stream_m_data_o(dout), .stream_m_valid_o(vld),
    .stream_m_ready_i(ready), .stream_m_last_o(lst), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_bw();
    int b;
    b = int'(bsz >> 2);
    return (b == 0) ? 1 : b;
  endfunction

  task automatic m_clear();
    mq.delete();
    m_pres = 1'b0;
    m_wc   = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_edge();
    bit full, x, l;
    int old;
    if (rst || clr) begin
      m_clear();
    end else begin
      full = (mq.size() == DEPTH);
      l    = m_pres && (m_wc >= m_bw() - 1);
      x    = m_pres && ready;
      old  = mq.size();
      if (x) begin
        void'(mq.pop_front());
        old--;
        m_wc = l ? 0 : m_wc + 1;
      end
      if (wr) begin
        if (full) m_ovf = 1'b1;
        else mq.push_back(d);
      end
      m_pres = (old > 0);
    end
  endtask

  task automatic model_chk();
    chk("mdl_valid", vld, m_pres);
    chk("mdl_cnt", cnt, mq.size());
    chk("mdl_ovf", ovf, m_ovf);
    chk("mdl_last", lst, m_pres && (m_wc >= m_bw() - 1));
    if (m_pres) chk("mdl_data", dout, mq[0]);
  endtask

  // Inputs change at negedge; the model follows the rising edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_chk();
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] d;
    bit          rdy;
    bit          e_v;
    logic [31:0] e_d;
    logic [4:0]  e_c;
  } vec_t;

  vec_t tv[6];

  initial begin
    int k;
    tv[0] = '{1'b1, 32'h11, 1'b1, 1'b0, 32'h0,  5'd1};
    tv[1] = '{1'b1, 32'h12, 1'b1, 1'b1, 32'h11, 5'd2};
    tv[2] = '{1'b1, 32'h13, 1'b1, 1'b1, 32'h12, 5'd2};
    tv[3] = '{1'b1, 32'h14, 1'b1, 1'b1, 32'h13, 5'd2};
    tv[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h14, 5'd1};
    tv[5] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  5'd0};

    // Reset state
    @(negedge clk);
    chk("rst_valid", vld, 1'b0);
    chk("rst_cnt", cnt, 0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_last", lst, 1'b0);
    rst = 1'b0;
    cycle();

    // Four back-to-back writes, sink always ready
    for (int i = 0; i < 6; i++) begin
      wr = tv[i].wr; d = tv[i].d; ready = tv[i].rdy;
      cycle();
      chk("t1_valid", vld, tv[i].e_v);
      chk("t1_cnt", cnt, tv[i].e_c);
      if (tv[i].e_v) chk("t1_data", dout, tv[i].e_d);
      chk("t1_last", lst, 1'b0);
    end

    // Overflow: 17 writes into a stalled FIFO, then drain
    ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr = 1'b1; d = 32'h100 + i;
      cycle();
    end
    wr = 1'b0;
    chk("t2_cnt_full", cnt, 16);
    chk("t2_ovf", ovf, 1'b1);
    chk("t2_head", dout, 32'h100);
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t2_order", dout, 32'h100 + i);
      cycle();
    end
    chk("t2_cnt_empty", cnt, 0);
    chk("t2_valid_empty", vld, 1'b0);
    ready = 1'b0;

    // Last on every 3rd word with buf_size=12
    clr = 1'b1; cycle(); clr = 1'b0;
    bsz = 32'd12; ready = 1'b1;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      wr = (c < 9); d = 32'h300 + c;
      if (vld) begin
        k++;
        chk("t3_last", lst, (k % 3) == 0);
      end
      cycle();
    end
    wr = 1'b0;
    chk("t3_count", k, 9);

    // Full with simultaneous write and transfer
    ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; d = 32'h400 + i;
      cycle();
    end
    chk("t4_cnt_full", cnt, 16);
    chk("t4_ovf_pre", ovf, 1'b0);
    wr = 1'b1; d = 32'hDEAD; ready = 1'b1;
    cycle();
    wr = 1'b0; ready = 1'b0;
    chk("t4_cnt", cnt, 15);
    chk("t4_ovf", ovf, 1'b1);
    chk("t4_next", dout, 32'h401);

    // Flush with 5 words held and a simultaneous write
    ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    ready = 1'b0;
    cycle();
    chk("t5_cnt_held", cnt, 5);
    clr = 1'b1; wr = 1'b1; d = 32'hBAD;
    cycle();
    clr = 1'b0; wr = 1'b0;
    chk("t5_cnt", cnt, 0);
    chk("t5_valid", vld, 1'b0);
    chk("t5_ovf", ovf, 1'b0);
    ready = 1'b1;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      wr = (c < 3); d = 32'hAA + c;
      if (vld) begin
        k++;
        if (k == 1) chk("t5_first", dout, 32'hAA);
        chk("t5_last", lst, k == 3);
      end
      cycle();
    end
    wr = 1'b0;
    chk("t5_count", k, 3);

    // Asynchronous reset between edges
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; d = 32'h600 + i; ready = (i != 2);
      cycle();
    end
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", vld, 1'b0);
    chk("t6_cnt", cnt, 0);
    chk("t6_ovf", ovf, 1'b0);
    chk("t6_last", lst, 1'b0);
    m_clear();
    wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      wr    = ($urandom % 10) < 7;
      d     = $urandom;
      ready = ($urandom % 10) < (((i / 300) % 2) != 0 ? 2 : 8);
      clr   = ($urandom % 64) == 0;
      if (($urandom % 100) == 0) bsz = $urandom_range(0, 80);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
